// File: rtl/ov7670_pkg.sv
// ov7670_pkg
//   Definitions shared by the camera frame-capture path: frame writer state
//   encoding, default active-window geometry and the RGB565 -> RGB444 field
//   positions (top four bits of each colour field).
//   No ports.
package ov7670_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } fw_state_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // MSB of each colour field inside an RGB565 word.
  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_B_MSB = 4;

  function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
    return {p[RGB565_R_MSB -: 4], p[RGB565_G_MSB -: 4], p[RGB565_B_MSB -: 4]};
  endfunction

endpackage

// File: rtl/frame_writer_if.sv
// frame_writer_if
//   Bundles the camera-side pixel stream and the frame-buffer write port.
//   Parameter ADDR_W : frame-buffer address width.
//   Camera side : vsync, href, pix_data[15:0], pix_valid
//   Buffer side : wr_en, wr_addr[ADDR_W-1:0], wr_data[11:0]
//   Modports    : master = camera source / buffer sink, slave = frame writer.
interface frame_writer_if #(
  parameter int ADDR_W = 19
);
  logic              vsync;
  logic              href;
  logic [15:0]       pix_data;
  logic              pix_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;

  modport master (
    output vsync, href, pix_data, pix_valid,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  vsync, href, pix_data, pix_valid,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Registers a level once and flags its transitions by comparing the live
//   input with the registered copy.
//   clk, rst_n : clock, async active-low reset (registered level resets to 0)
//   d          : level input
//   rise, fall : one-cycle pulses while d differs from its registered copy
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign rise = d & ~q;
  assign fall = ~d & q;
endmodule

// File: rtl/frame_writer.sv
// frame_writer
//   Captures whole camera frames into a frame buffer as RGB444 pixels.
//   Waits for a clean frame boundary (vsync rise) before capturing, writes
//   in-window pixels at consecutive addresses one cycle after acceptance,
//   and flags short/long lines.
//   Build option: FRAME_WRITER_DECIMATE_EN stores only even-x / even-y pixels
//   (dense half-resolution image); undefined stores every in-window pixel.
//   Ports:
//     clk, rst_n  : pixel clock, async active-low reset
//     capture_en  : permits capture of the next frame
//     bus         : frame_writer_if.slave (camera stream in, buffer writes out)
//     frame_done  : one-cycle pulse at end of a captured frame
//     line_err    : one-cycle pulse when a line's pixel count != H_ACTIVE
//     busy        : high while ARMED or ACTIVE
//
//   state  | meaning
//   IDLE   | not capturing; arms on vsync rise with capture_en
//   ARMED  | in vertical blanking, waiting for vsync fall to start frame
//   ACTIVE | capturing lines until the next vsync rise
module frame_writer
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture_en,
  frame_writer_if.slave bus,
  output logic          frame_done,
  output logic          line_err,
  output logic          busy
);
  // x saturates one past H_ACTIVE so an over-long line stays distinguishable.
  localparam int XW = $clog2(H_ACTIVE + 2);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_SAT = XW'(H_ACTIVE + 1);
  localparam logic [YW-1:0] Y_END = YW'(V_ACTIVE);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ARMED  = ST_ARMED;
  localparam logic [1:0] ACTIVE = ST_ACTIVE;

  logic [1:0]        state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [11:0]       wr_data_q;

  logic vs_rise, vs_fall, hr_fall, hr_rise_unused;
  logic accept, keep;

  sync_edge_det u_vs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  sync_edge_det u_hr_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.href),
    .rise (hr_rise_unused),
    .fall (hr_fall)
  );

  assign accept = bus.pix_valid & bus.href;

`ifdef FRAME_WRITER_DECIMATE_EN
  assign keep = (x < X_END) && (y < Y_END) && !x[0] && !y[0];
`else
  assign keep = (x < X_END) && (y < Y_END);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      wr_en_q    <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_en && vs_rise) state <= ARMED;
        end
        ARMED: begin
          if (vs_fall) begin
            state <= ACTIVE;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
          end
        end
        ACTIVE: begin
          // End of frame wins over a coincident line end; the partial line
          // is abandoned without a line error.
          if (vs_rise) begin
            frame_done <= 1'b1;
            state      <= capture_en ? ARMED : IDLE;
          end else if (hr_fall) begin
            line_err <= (x != X_END);
            x        <= '0;
            if (y != Y_END) y <= y + YW'(1);
          end else if (accept) begin
            if (x != X_SAT) x <= x + XW'(1);
            if (keep) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr;
              wr_data_q <= rgb565_to_444(bus.pix_data);
              addr      <= addr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy        = (state == ARMED) || (state == ACTIVE);

endmodule
